// File: rtl/random_pulse_scheduler_pkg.sv
// Shared types and constants for the random pulse scheduler: FSM states, LFSR
// taps and seed, datapath widths and the gap arithmetic.
package rpg_pkg;

  localparam int RPG_LFSR_W  = 16;
  localparam int RPG_CNT_W   = 8;
  localparam int RPG_GAP_W   = 9;
  localparam int RPG_WIDTH_W = 4;
  localparam int RPG_BYTE_W  = 8;

  localparam logic [RPG_LFSR_W-1:0] RPG_LFSR_TAPS    = 16'hB400;
  localparam logic [RPG_LFSR_W-1:0] RPG_SEED_DEFAULT = 16'h0001;

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    PULSE,
    DONE
  } rpg_state_t;

  // Nine bits so that gap_min plus the masked random byte never wraps.
  function automatic logic [RPG_GAP_W-1:0] rpgGapValue(
    input logic [RPG_BYTE_W-1:0] gapMin,
    input logic [RPG_BYTE_W-1:0] gapMask,
    input logic [RPG_BYTE_W-1:0] lfsrLow
  );
    return {1'b0, gapMin} + {1'b0, (lfsrLow & gapMask)};
  endfunction

  function automatic logic [RPG_WIDTH_W-1:0] rpgEffWidth(input logic [RPG_WIDTH_W-1:0] w);
    return (w == '0) ? RPG_WIDTH_W'(1) : w;
  endfunction

endpackage

// File: rtl/random_pulse_scheduler_if.sv
// Control/status bundle between the wrapper I/O and the scheduler; the
// scheduler takes the slave side.
interface random_pulse_scheduler_if
  import rpg_pkg::*;
#(
  parameter int CNT_W = RPG_CNT_W
);

  logic                     ena;
  logic                     start;
  logic                     abort;
  logic                     seed_load;
  logic [RPG_LFSR_W-1:0]    seed;
  logic [CNT_W-1:0]         burst_len;
  logic [RPG_WIDTH_W-1:0]   pulse_width;
  logic [RPG_BYTE_W-1:0]    gap_min;
  logic [RPG_BYTE_W-1:0]    gap_mask;
  logic                     pulse;
  logic                     busy;
  logic                     done;
  logic [CNT_W-1:0]         pulse_count;
  logic [RPG_LFSR_W-1:0]    lfsr_q;

  modport master (
    output ena, start, abort, seed_load, seed, burst_len, pulse_width, gap_min, gap_mask,
    input  pulse, busy, done, pulse_count, lfsr_q
  );

  modport slave (
    input  ena, start, abort, seed_load, seed, burst_len, pulse_width, gap_min, gap_mask,
    output pulse, busy, done, pulse_count, lfsr_q
  );

endinterface

// File: rtl/random_pulse_scheduler_lfsr.sv
// 16-bit right-shifting Galois LFSR; a zero seed is replaced by the default so
// the all-zero lock-up state can never be entered.
module rpg_lfsr
  import rpg_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ena_i,
  input  logic                  load_i,
  input  logic [RPG_LFSR_W-1:0] seed_i,
  output logic [RPG_LFSR_W-1:0] q_o
);

  logic [RPG_LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (ena_i) begin
      if (load_i) begin
        lfsr_d = (seed_i == '0) ? RPG_SEED_DEFAULT : seed_i;
      end else begin
        lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? RPG_LFSR_TAPS : '0);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= RPG_SEED_DEFAULT;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/random_pulse_scheduler.sv
// Burst sequencer: after start, emits burst_len pulses of a fixed width, each
// preceded by a gap of gap_min plus a masked LFSR byte.
module random_pulse_scheduler
  import rpg_pkg::*;
#(
  parameter int LFSR_W = RPG_LFSR_W,
  parameter int CNT_W  = RPG_CNT_W
)(
  input  logic                     clk,
  input  logic                     rst_n,
  random_pulse_scheduler_if.slave  bus
);

  rpg_state_t               state_q, state_d;
  logic                     pulse_q, pulse_d;
  logic [CNT_W-1:0]         pulseCount_q, pulseCount_d;
  logic [CNT_W-1:0]         burstLen_q, burstLen_d;
  logic [RPG_GAP_W-1:0]     gapCnt_q, gapCnt_d;
  logic [RPG_WIDTH_W-1:0]   widthCnt_q, widthCnt_d;
  logic [RPG_WIDTH_W-1:0]   width_q, width_d;
  logic [RPG_BYTE_W-1:0]    gapMin_q, gapMin_d;
  logic [RPG_BYTE_W-1:0]    gapMask_q, gapMask_d;

  logic [LFSR_W-1:0]        lfsrQ;
  logic                     seedLoad;
  logic [CNT_W-1:0]         countInc;

  assign seedLoad = bus.ena && bus.seed_load && (state_q == IDLE);
  assign countInc = pulseCount_q + CNT_W'(1);

  rpg_lfsr u_lfsr (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .ena_i  (bus.ena),
    .load_i (seedLoad),
    .seed_i (bus.seed),
    .q_o    (lfsrQ)
  );

  // With ena low nothing moves, so a pulse in flight stretches rather than ends early.
  always_comb begin
    state_d      = state_q;
    pulse_d      = pulse_q;
    pulseCount_d = pulseCount_q;
    burstLen_d   = burstLen_q;
    gapCnt_d     = gapCnt_q;
    widthCnt_d   = widthCnt_q;
    width_d      = width_q;
    gapMin_d     = gapMin_q;
    gapMask_d    = gapMask_q;

    if (bus.ena) begin
      if (state_q != IDLE && bus.abort) begin
        state_d = IDLE;
        pulse_d = 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (!bus.seed_load && bus.start) begin
              burstLen_d   = bus.burst_len;
              width_d      = rpgEffWidth(bus.pulse_width);
              gapMin_d     = bus.gap_min;
              gapMask_d    = bus.gap_mask;
              pulseCount_d = '0;
              if (bus.burst_len == '0) begin
                state_d = DONE;
              end else begin
                gapCnt_d = rpgGapValue(bus.gap_min, bus.gap_mask, lfsrQ[RPG_BYTE_W-1:0]);
                state_d  = GAP;
              end
            end
          end
          GAP: begin
            if (gapCnt_q == '0) begin
              state_d    = PULSE;
              pulse_d    = 1'b1;
              widthCnt_d = width_q - 4'd1;
            end else begin
              gapCnt_d = gapCnt_q - 9'd1;
            end
          end
          PULSE: begin
            if (widthCnt_q == '0) begin
              pulse_d      = 1'b0;
              pulseCount_d = countInc;
              if (countInc == burstLen_q) begin
                state_d = DONE;
              end else begin
                gapCnt_d = rpgGapValue(gapMin_q, gapMask_q, lfsrQ[RPG_BYTE_W-1:0]);
                state_d  = GAP;
              end
            end else begin
              widthCnt_d = widthCnt_q - 4'd1;
            end
          end
          DONE: begin
            state_d = IDLE;
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pulse_q      <= 1'b0;
      pulseCount_q <= '0;
      burstLen_q   <= '0;
      gapCnt_q     <= '0;
      widthCnt_q   <= '0;
      width_q      <= '0;
      gapMin_q     <= '0;
      gapMask_q    <= '0;
    end else begin
      state_q      <= state_d;
      pulse_q      <= pulse_d;
      pulseCount_q <= pulseCount_d;
      burstLen_q   <= burstLen_d;
      gapCnt_q     <= gapCnt_d;
      widthCnt_q   <= widthCnt_d;
      width_q      <= width_d;
      gapMin_q     <= gapMin_d;
      gapMask_q    <= gapMask_d;
    end
  end

  assign bus.pulse       = pulse_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.pulse_count = pulseCount_q;
  assign bus.lfsr_q      = lfsrQ;

endmodule

// File: tb/tb_random_pulse_scheduler.sv
// Directed bench for random_pulse_scheduler: pulse edges and done strobes are
// scored against a queue of hand-computed events, status is checked directly.
module tb_random_pulse_scheduler;

  typedef enum int {EV_RISE, EV_FALL, EV_DONE} evKind_e;

  typedef struct {
    evKind_e kind;
    int      cyc;
    int      count;
  } expEv_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  logic prevPulse;
  expEv_t expQ[$];

  random_pulse_scheduler_if #(.CNT_W(8)) bus ();

  random_pulse_scheduler #(.LFSR_W(16), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] lfsrNext(input logic [15:0] q);
    return (q >> 1) ^ (q[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic pushEv(input evKind_e kind, input int at, input int count);
    expEv_t e;
    e.kind  = kind;
    e.cyc   = at;
    e.count = count;
    expQ.push_back(e);
  endtask

  task automatic scoreEvent(input evKind_e kind, input int count);
    expEv_t e;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL sb_unexpected: got event %0d at cycle %0d, expected no event", kind, cyc);
    end else begin
      e = expQ.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.count != count) begin
        errors++;
        $display("[TB] FAIL sb_event: got kind %0d cycle %0d count %0d, expected kind %0d cycle %0d count %0d",
                 kind, cyc, count, e.kind, e.cyc, e.count);
      end
    end
  endtask

  // Monitor: scores every pulse edge and done strobe against the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.pulse && !prevPulse) scoreEvent(EV_RISE, 0);
      if (!bus.pulse && prevPulse) scoreEvent(EV_FALL, 0);
      if (bus.done) scoreEvent(EV_DONE, int'(bus.pulse_count));
    end
    prevPulse <= bus.pulse;
  end

  task automatic applyStimulus(input logic [7:0] bl, input logic [3:0] pw,
                               input logic [7:0] gmin, input logic [7:0] gmask);
    bus.burst_len   = bl;
    bus.pulse_width = pw;
    bus.gap_min     = gmin;
    bus.gap_mask    = gmask;
  endtask

  task automatic startBurst();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0;
    int g;
    logic [15:0] lfsrTbl [4];
    logic [15:0] model;
    lfsrTbl[0] = 16'h0001;
    lfsrTbl[1] = 16'hB400;
    lfsrTbl[2] = 16'h5A00;
    lfsrTbl[3] = 16'h2D00;
    checks = 0;
    errors = 0;
    prevPulse = 1'b0;
    rst_n = 1'b0;
    bus.ena = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.seed_load = 1'b0;
    bus.seed = 16'h0000;
    applyStimulus(8'd0, 4'd0, 8'd0, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset values
    checkOutput("rst_lfsr", bus.lfsr_q, 16'h0001);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_pulse", bus.pulse, 1'b0);
    checkOutput("rst_done", bus.done, 1'b0);
    checkOutput("rst_count", bus.pulse_count, 8'd0);

    // zero seed substitution and the first LFSR steps
    bus.ena = 1'b1;
    bus.seed = 16'h0000;
    bus.seed_load = 1'b1;
    @(negedge clk);
    bus.seed_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("lfsr_seq%0d", i), bus.lfsr_q, lfsrTbl[i]);
      @(negedge clk);
    end

    // seed_load beats start in the same cycle
    applyStimulus(8'd2, 4'd2, 8'd3, 8'd0);
    bus.seed = 16'hBEEF;
    bus.seed_load = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.seed_load = 1'b0;
    bus.start = 1'b0;
    checkOutput("seedstart_lfsr", bus.lfsr_q, 16'hBEEF);
    checkOutput("seedstart_busy", bus.busy, 1'b0);
    @(negedge clk);
    checkOutput("seedstart_busy2", bus.busy, 1'b0);
    checkOutput("seedstart_step", bus.lfsr_q, lfsrNext(16'hBEEF));

    // basic burst: G=3, W=2, two pulses
    applyStimulus(8'd2, 4'd2, 8'd3, 8'd0);
    c0 = cyc;
    pushEv(EV_RISE, c0 + 5, 0);
    pushEv(EV_FALL, c0 + 7, 0);
    pushEv(EV_RISE, c0 + 11, 0);
    pushEv(EV_FALL, c0 + 13, 0);
    pushEv(EV_DONE, c0 + 13, 2);
    startBurst();
    checkOutput("basic_busy_rise", bus.busy, 1'b1);
    repeat (13) @(negedge clk);
    checkOutput("basic_idle", bus.busy, 1'b0);
    checkOutput("basic_count", bus.pulse_count, 8'd2);

    // full mask: G = gap_min + seed low byte
    bus.seed = 16'h12A3;
    bus.seed_load = 1'b1;
    applyStimulus(8'd1, 4'd1, 8'd2, 8'hFF);
    @(negedge clk);
    bus.seed_load = 1'b0;
    g = 2 + (8'hA3 & 8'hFF);
    c0 = cyc;
    pushEv(EV_RISE, c0 + g + 2, 0);
    pushEv(EV_FALL, c0 + g + 3, 0);
    pushEv(EV_DONE, c0 + g + 3, 1);
    startBurst();
    repeat (g + 5) @(negedge clk);
    checkOutput("mask_idle", bus.busy, 1'b0);

    // burst_len of zero: done one cycle after start, no pulse
    applyStimulus(8'd0, 4'd2, 8'd3, 8'd0);
    c0 = cyc;
    pushEv(EV_DONE, c0 + 1, 0);
    startBurst();
    repeat (4) @(negedge clk);
    checkOutput("zero_len_pulse", bus.pulse, 1'b0);

    // pulse_width of zero behaves as one
    applyStimulus(8'd1, 4'd0, 8'd0, 8'd0);
    c0 = cyc;
    pushEv(EV_RISE, c0 + 2, 0);
    pushEv(EV_FALL, c0 + 3, 0);
    pushEv(EV_DONE, c0 + 3, 1);
    startBurst();
    repeat (5) @(negedge clk);

    // abort during the second pulse
    applyStimulus(8'd3, 4'd3, 8'd1, 8'd0);
    c0 = cyc;
    pushEv(EV_RISE, c0 + 3, 0);
    pushEv(EV_FALL, c0 + 6, 0);
    pushEv(EV_RISE, c0 + 8, 0);
    pushEv(EV_FALL, c0 + 10, 0);
    startBurst();
    repeat (8) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checkOutput("abort_busy", bus.busy, 1'b0);
    checkOutput("abort_pulse", bus.pulse, 1'b0);
    checkOutput("abort_count", bus.pulse_count, 8'd1);
    repeat (5) @(negedge clk);

    // ena low for five cycles mid-pulse stretches a W=3 pulse to 8 cycles
    bus.seed = 16'h0000;
    bus.seed_load = 1'b1;
    applyStimulus(8'd1, 4'd3, 8'd0, 8'd0);
    @(negedge clk);
    bus.seed_load = 1'b0;
    c0 = cyc;
    pushEv(EV_RISE, c0 + 2, 0);
    pushEv(EV_FALL, c0 + 10, 0);
    pushEv(EV_DONE, c0 + 10, 1);
    startBurst();
    @(negedge clk);
    @(negedge clk);
    bus.ena = 1'b0;
    model = lfsrNext(lfsrNext(lfsrNext(16'h0001)));
    repeat (3) @(negedge clk);
    checkOutput("ena_lfsr_frozen", bus.lfsr_q, model);
    checkOutput("ena_pulse_held", bus.pulse, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("ena_lfsr_frozen2", bus.lfsr_q, model);
    bus.ena = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("ena_idle", bus.busy, 1'b0);

    // asynchronous reset in the middle of a pulse
    applyStimulus(8'd1, 4'd8, 8'd0, 8'd0);
    c0 = cyc;
    pushEv(EV_RISE, c0 + 2, 0);
    startBurst();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_pulse", bus.pulse, 1'b0);
    checkOutput("arst_busy", bus.busy, 1'b0);
    checkOutput("arst_lfsr", bus.lfsr_q, 16'h0001);
    checkOutput("arst_count", bus.pulse_count, 8'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    checkOutput("sb_drained", expQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
